// File: rtl/uart_csr_bank.sv
// uart_csr_bank
// Control/status register bank for NCH UART channels. Each channel has
// CTRL, STATUS (sticky, write-1-to-clear), IEN and BAUD registers. The bank
// also produces a one-cycle TX start strobe and a registered level interrupt
// per channel. Bus reads are registered: data appears one cycle after rd_en.
module uart_csr_bank #(
  parameter int         NCH      = 2,
  parameter logic [7:0] BAUD_RST = 8'd26,
  localparam int        AW       = (($clog2(NCH) + 2) < 3) ? 3 : ($clog2(NCH) + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [AW-1:0]    addr,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  input  logic [NCH-1:0]   tx_active,
  input  logic [NCH-1:0]   tx_done,
  input  logic [NCH-1:0]   rx_done,
  output logic [8*NCH-1:0] ctrl_o,
  output logic [8*NCH-1:0] baud_o,
  output logic [NCH-1:0]   tx_start,
  output logic [NCH-1:0]   irq
);

  localparam int         CW          = AW - 2;
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_IEN     = 2'd2;
  localparam logic [1:0] REG_BAUD    = 2'd3;
  // STATUS bits that are sticky / maskable: RXDONE, TXDONE, RXOVR
  localparam logic [7:0] STICKY_MASK = 8'hD0;

  // Sticky bit update: a set in the same cycle as a clear wins.
  function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
    return set | (cur & ~clr);
  endfunction

  // CTRL bit0 (TX_GO) is never stored, so only bits [7:1] are kept.
  logic [NCH-1:0][6:0] ctrl_q;
  logic [NCH-1:0][7:0] ien_q;
  logic [NCH-1:0][7:0] baud_q;
  logic [NCH-1:0]      rxdone_q;
  logic [NCH-1:0]      txdone_q;
  logic [NCH-1:0]      rxovr_q;
  logic [NCH-1:0][7:0] status_w;

  logic [CW-1:0]       ch_sel;
  logic [1:0]          reg_sel;
  logic [NCH-1:0]      hit;
  logic [NCH-1:0]      w_ctrl;
  logic [NCH-1:0]      w_stat;
  logic [NCH-1:0]      w_ien;
  logic [NCH-1:0]      w_baud;
  logic [NCH-1:0]      go;
  logic [7:0]          rd_val;

  assign ch_sel  = addr[AW-1:2];
  assign reg_sel = addr[1:0];

  // Channel decode; channel indices >= NCH match nothing, so their writes
  // are dropped and their reads fall through to zero.
  always_comb begin
    hit = '0;
    for (int c = 0; c < NCH; c++) begin
      hit[c] = (ch_sel == CW'(c));
    end
  end

  assign w_ctrl = hit & {NCH{wr_en && (reg_sel == REG_CTRL)}};
  assign w_stat = hit & {NCH{wr_en && (reg_sel == REG_STATUS)}};
  assign w_ien  = hit & {NCH{wr_en && (reg_sel == REG_IEN)}};
  assign w_baud = hit & {NCH{wr_en && (reg_sel == REG_BAUD)}};

  // A GO request is accepted only if the written TX_EN is set and the
  // transmitter is idle at that moment; otherwise it is silently dropped.
  assign go = w_ctrl & {NCH{wdata[0] & wdata[2]}} & ~tx_active;

  // Assemble the readable STATUS word, with TXACT as a live copy.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      status_w[c] = {rxdone_q[c], txdone_q[c], tx_active[c], rxovr_q[c], 4'b0000};
    end
  end

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NCH; c++) begin
      if (hit[c]) begin
        case (reg_sel)
          REG_CTRL:   rd_val = {ctrl_q[c], 1'b0};
          REG_STATUS: rd_val = status_w[c];
          REG_IEN:    rd_val = ien_q[c];
          REG_BAUD:   rd_val = baud_q[c];
          default:    rd_val = '0;
        endcase
      end
    end
  end

  // Drive the packed per-channel CTRL view; TX_GO always reads back as 0.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      ctrl_o[8*c +: 8] = {ctrl_q[c], 1'b0};
    end
  end

  assign baud_o = baud_q;

  // Configuration registers: CTRL, IEN and BAUD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      ien_q  <= '0;
      baud_q <= {NCH{BAUD_RST}};
    end else if (init) begin
      ctrl_q <= '0;
      ien_q  <= '0;
      baud_q <= {NCH{BAUD_RST}};
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_ctrl[c]) ctrl_q[c] <= wdata[7:1];
        if (w_ien[c])  ien_q[c]  <= wdata & STICKY_MASK;
        if (w_baud[c]) baud_q[c] <= wdata;
      end
    end
  end

  // Sticky status bits; RXOVR looks at RXDONE before this cycle's clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxdone_q <= '0;
      txdone_q <= '0;
      rxovr_q  <= '0;
    end else if (init) begin
      rxdone_q <= '0;
      txdone_q <= '0;
      rxovr_q  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        rxdone_q[c] <= sticky_next(rxdone_q[c], rx_done[c], w_stat[c] & wdata[7]);
        txdone_q[c] <= sticky_next(txdone_q[c], tx_done[c], w_stat[c] & wdata[6]);
        rxovr_q[c]  <= sticky_next(rxovr_q[c], rx_done[c] & rxdone_q[c],
                                   w_stat[c] & wdata[4]);
      end
    end
  end

  // Registered interrupt from the stored status and enable mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= '0;
    end else if (init) begin
      irq <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        irq[c] <= |(status_w[c] & ien_q[c] & STICKY_MASK);
      end
    end
  end

  // One-cycle TX start strobe following an accepted GO write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start <= '0;
    end else if (init) begin
      tx_start <= '0;
    end else begin
      tx_start <= go;
    end
  end

  // Registered read data; holds its value between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (init) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_uart_csr_bank.sv
// tb_uart_csr_bank
// Directed and randomized stimulus for uart_csr_bank with three channels,
// compared every cycle against a byte-level behavioural model.
module tb_uart_csr_bank;

  localparam int NCH = 3;
  localparam int AW  = 4;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             init      = 1'b0;
  logic [AW-1:0]    addr      = '0;
  logic             wr_en     = 1'b0;
  logic             rd_en     = 1'b0;
  logic [7:0]       wdata     = '0;
  logic [7:0]       rdata;
  logic [NCH-1:0]   tx_active = '0;
  logic [NCH-1:0]   tx_done   = '0;
  logic [NCH-1:0]   rx_done   = '0;
  logic [8*NCH-1:0] ctrl_o;
  logic [8*NCH-1:0] baud_o;
  logic [NCH-1:0]   tx_start;
  logic [NCH-1:0]   irq;

  int total = 0;
  int bad   = 0;

  uart_csr_bank #(.NCH(NCH), .BAUD_RST(8'd26)) dut (
    .clk(clk), .rst(rst), .init(init), .addr(addr), .wr_en(wr_en),
    .rd_en(rd_en), .wdata(wdata), .rdata(rdata), .tx_active(tx_active),
    .tx_done(tx_done), .rx_done(rx_done), .ctrl_o(ctrl_o), .baud_o(baud_o),
    .tx_start(tx_start), .irq(irq)
  );

  always #5 clk = ~clk;

  // Model state: whole register bytes per channel.
  logic [7:0]     m_ctrl [NCH];
  logic [7:0]     m_st   [NCH];
  logic [7:0]     m_ien  [NCH];
  logic [7:0]     m_baud [NCH];
  logic [7:0]     m_rdata;
  logic [NCH-1:0] m_txs;
  logic [NCH-1:0] m_irq;

  function automatic logic [7:0] next_status(input logic [7:0] old, input logic rxd,
                                             input logic txd, input logic [7:0] clr);
    logic [7:0] set;
    set    = 8'h00;
    set[7] = rxd;
    set[6] = txd;
    set[4] = rxd & old[7];
    return (old & ~clr) | set;
  endfunction

  function automatic logic [7:0] model_read(input int ch, input int r);
    if (ch >= NCH) return 8'h00;
    case (r)
      0:       return m_ctrl[ch] & 8'hFE;
      1:       return m_st[ch] | (tx_active[ch] ? 8'h20 : 8'h00);
      2:       return m_ien[ch];
      default: return m_baud[ch];
    endcase
  endfunction

  function automatic logic [8*NCH-1:0] exp_ctrl();
    logic [8*NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[8*c +: 8] = m_ctrl[c] & 8'hFE;
    return v;
  endfunction

  function automatic logic [8*NCH-1:0] exp_baud();
    logic [8*NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[8*c +: 8] = m_baud[c];
    return v;
  endfunction

  // Behavioural model: register effects at address 4*ch+reg.
  always @(posedge clk or posedge rst) begin
    if (rst || init) begin
      for (int c = 0; c < NCH; c++) begin
        m_ctrl[c] <= 8'h00;
        m_st[c]   <= 8'h00;
        m_ien[c]  <= 8'h00;
        m_baud[c] <= 8'd26;
      end
      m_rdata <= 8'h00;
      m_txs   <= '0;
      m_irq   <= '0;
    end else begin
      if (rd_en) m_rdata <= model_read(int'(addr[3:2]), int'(addr[1:0]));
      for (int c = 0; c < NCH; c++) begin
        m_irq[c] <= ((m_st[c] & m_ien[c] & 8'hD0) != 8'h00);
        m_st[c]  <= next_status(m_st[c], rx_done[c], tx_done[c],
                      (wr_en && int'(addr) == 4*c+1) ? (wdata & 8'hD0) : 8'h00);
        m_txs[c] <= wr_en && int'(addr) == 4*c && wdata[0] && wdata[2] && !tx_active[c];
        if (wr_en && int'(addr) == 4*c)   m_ctrl[c] <= wdata;
        if (wr_en && int'(addr) == 4*c+2) m_ien[c]  <= wdata & 8'hD0;
        if (wr_en && int'(addr) == 4*c+3) m_baud[c] <= wdata;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    check("rdata",    32'(rdata),    32'(m_rdata));
    check("ctrl_o",   32'(ctrl_o),   32'(exp_ctrl()));
    check("baud_o",   32'(baud_o),   32'(exp_baud()));
    check("tx_start", 32'(tx_start), 32'(m_txs));
    check("irq",      32'(irq),      32'(m_irq));
  end

  task automatic step();
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rx_done = '0;
    tx_done = '0;
    init    = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    step();
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    addr  = a;
    rd_en = 1'b1;
    step();
    d = rdata;
  endtask

  initial begin
    logic [7:0] d;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_rdata",    32'(rdata),    32'h0);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_irq",      32'(irq),      32'h0);
    check("rst_ctrl_o",   32'(ctrl_o),   32'h0);
    check("rst_baud_o",   32'(baud_o),   32'h1A1A1A);
    rst = 1'b0;

    // Reset values of channels 0 and NCH-1, and the unmapped channel
    rd(4'h0, d); check("rst_ctrl0",  32'(d), 32'h00);
    rd(4'h1, d); check("rst_stat0",  32'(d), 32'h00);
    rd(4'h2, d); check("rst_ien0",   32'(d), 32'h00);
    rd(4'h3, d); check("rst_baud0",  32'(d), 32'h1A);
    rd(4'h8, d); check("rst_ctrl2",  32'(d), 32'h00);
    rd(4'h9, d); check("rst_stat2",  32'(d), 32'h00);
    rd(4'hA, d); check("rst_ien2",   32'(d), 32'h00);
    rd(4'hB, d); check("rst_baud2",  32'(d), 32'h1A);
    rd(4'hF, d); check("ch3_baud",   32'(d), 32'h00);
    wr(4'hC, 8'hFF);
    rd(4'hC, d); check("ch3_ctrl",   32'(d), 32'h00);

    // TX GO strobe, accepted then blocked by tx_active
    wr(4'h4, 8'h05); check("go_strobe",   32'(tx_start), 32'h2);
    step();          check("go_one_cyc",  32'(tx_start), 32'h0);
    rd(4'h4, d);     check("ctrl1_read",  32'(d),        32'h04);
    tx_active = 3'b010;
    wr(4'h4, 8'h05); check("go_blocked",  32'(tx_start), 32'h0);
    tx_active = 3'b000;

    // RX status, overrun and interrupt latency
    wr(4'h2, 8'h80);
    rx_done = 3'b001;
    step();          check("irq_lat_n",   32'(irq[0]), 32'h0);
    step();          check("irq_lat_n1",  32'(irq[0]), 32'h1);
    rd(4'h1, d);     check("stat0_rxd",   32'(d),      32'h80);
    rx_done = 3'b001;
    step();
    rd(4'h1, d);     check("stat0_ovr",   32'(d),      32'h90);
    wr(4'h1, 8'h80);
    rd(4'h1, d);     check("stat0_w1c",   32'(d),      32'h10);
    check("irq_cleared", 32'(irq[0]), 32'h0);

    // RX clear colliding with rx_done: set wins, overrun uses pre-clear RXDONE
    wr(4'h1, 8'hD0);
    rx_done = 3'b001;
    step();
    addr = 4'h1; wdata = 8'h80; wr_en = 1'b1; rx_done = 3'b001;
    step();
    rd(4'h1, d);     check("rx_collide",  32'(d),      32'h90);

    // TXDONE set/clear collision on channel 1
    tx_done = 3'b010;
    step();
    addr = 4'h5; wdata = 8'h40; wr_en = 1'b1; tx_done = 3'b010;
    step();
    rd(4'h5, d);     check("tx_collide",  32'(d),      32'h40);
    wr(4'h5, 8'h40);
    rd(4'h5, d);     check("tx_w1c",      32'(d),      32'h00);

    // Live TXACT bit
    tx_active = 3'b100;
    rd(4'h9, d);     check("txact2",      32'(d),      32'h20);
    tx_active = 3'b000;

    // BAUD write with simultaneous read returns the old value
    addr = 4'h3; wdata = 8'h0C; wr_en = 1'b1; rd_en = 1'b1;
    step();          check("rw_old",      32'(rdata),      32'h1A);
    check("baud_o0", 32'(baud_o[7:0]), 32'h0C);
    rd(4'h3, d);     check("baud0_new",   32'(d),          32'h0C);

    // init with populated state and a GO write in the same cycle
    wr(4'h6, 8'hD0);
    tx_done = 3'b010;
    step();
    step();          check("irq1_pre",    32'(irq[1]),     32'h1);
    addr = 4'h8; wdata = 8'h05; wr_en = 1'b1; init = 1'b1;
    step();
    check("init_go",     32'(tx_start), 32'h0);
    check("init_irq",    32'(irq),      32'h0);
    check("init_ctrl_o", 32'(ctrl_o),   32'h0);
    check("init_baud_o", 32'(baud_o),   32'h1A1A1A);
    rd(4'h6, d);     check("init_ien1",   32'(d),          32'h00);
    rd(4'h5, d);     check("init_stat1",  32'(d),          32'h00);
    rd(4'h3, d);     check("init_baud0",  32'(d),          32'h1A);

    // Asynchronous reset while a strobe is in flight
    wr(4'h7, 8'h55);
    wr(4'h0, 8'h05); check("go_ch0",      32'(tx_start),   32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_go",     32'(tx_start), 32'h0);
    check("arst_ctrl_o", 32'(ctrl_o),   32'h0);
    check("arst_baud_o", 32'(baud_o),   32'h1A1A1A);
    check("arst_rdata",  32'(rdata),    32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      addr    = 4'($urandom_range(0, 15));
      wdata   = 8'($urandom);
      wr_en   = ($urandom_range(0, 9) < 3);
      rd_en   = ($urandom_range(0, 9) < 4);
      rx_done = 3'($urandom) & 3'($urandom);
      tx_done = 3'($urandom) & 3'($urandom);
      if ($urandom_range(0, 7) == 0) tx_active = 3'($urandom);
      init    = ($urandom_range(0, 99) == 0);
      step();
    end
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_csr_bank.md
# uart_csr_bank

Parametrised control/status register bank for NCH UART channels, sitting between the MCU data-memory bus and the UART TX/RX engines. Per channel it provides a control register, a sticky write-1-to-clear status register, an interrupt-enable mask and a baud divisor. It also generates a one-cycle TX start strobe and a level interrupt per channel. Bus reads return data one cycle after the read strobe.

## Interface
- NCH, 2: number of UART channels, 1..8.
- BAUD_RST, 8'd26: reset value of every baud divisor.
- AW, $clog2(NCH)+2 (derived localparam, min 3): bus address width.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- init  in  1  synchronous clear of all registers to reset values.
- addr  in  AW  addr[1:0] selects the register, addr[AW-1:2] selects the channel.
- wr_en  in  1  write strobe.
- rd_en  in  1  read strobe.
- wdata  in  8  write data.
- rdata  out  8  read data, registered.
- tx_active  in  NCH  live per-channel TX-busy level.
- tx_done  in  NCH  per-channel one-cycle pulse at the end of transmission.
- rx_done  in  NCH  per-channel one-cycle pulse when a byte is received.
- ctrl_o  out  8*NCH  CTRL registers; channel c is at [8c+7:8c].
- baud_o  out  8*NCH  baud divisors, same packing as ctrl_o.
- tx_start  out  NCH  one-cycle TX start strobe.
- irq  out  NCH  level interrupt.

## Operation
- Register map per channel (addr[1:0]): 0 CTRL, 1 STATUS, 2 IEN, 3 BAUD.
- CTRL: bit0 TX_GO (write-only, reads 0), bit1 RX_EN, bit2 TX_EN, bits[4:3] PARITY (00 none, 01 even, 10 odd, 11 reserved), bits[7:5] read/write scratch. ctrl_o bit0 is always 0.
- CTRL write with wdata[0]=1:
  - If TX_EN (post-write value) = 1 and tx_active[c] = 0, pulse tx_start[c] on the next cycle.
  - Otherwise the GO request is dropped.
- STATUS bits:
  - bit7 RXDONE: sticky, set by rx_done.
  - bit6 TXDONE: sticky, set by tx_done.
  - bit5 TXACT: live copy of tx_active, read-only.
  - bit4 RXOVR: sticky, set when rx_done arrives while RXDONE is already 1.
  - bits[3:0]: read 0.
- STATUS write is write-1-to-clear on bits 7, 6 and 4; other bits are ignored.
- Set/clear collision in the same cycle: set wins. RXOVR uses the pre-clear RXDONE, so an rx_done arriving in the same cycle as a clear of RXDONE (RXDONE=1 before the clear) still sets RXOVR.
- IEN: bits 7, 6 and 4 are read/write masks; all other bits read 0.
- irq[c] = |(STATUS[c] & IEN[c] & 8'hD0), registered.
- BAUD: plain read/write, driven directly onto baud_o.
- Accesses to channel index >= NCH: writes are ignored, reads return 0.
- wr_en and rd_en together: the write takes effect, and rdata returns the pre-write value.
- init: same effect as rst but synchronous. It has priority over the bus and over events. No tx_start is issued in an init cycle.

## Timing
- Reset/init values: CTRL 0, STATUS sticky bits 0, IEN 0, BAUD = BAUD_RST, rdata 0, tx_start 0, irq 0.
- Write visible on ctrl_o/baud_o one cycle after the wr_en edge.
- Read: rdata updates on the clock edge where rd_en=1 and is valid in the following cycle. rdata holds its value when rd_en=0.
- Status latency: event pulse at edge N → STATUS bit set after edge N → irq high after edge N+1.
- W1C at edge N → bit 0 after N → irq low after N+1 (unless re-set).
- tx_start: exactly one cycle wide, one cycle after the accepting CTRL write; never two back-to-back from a single write.
- rst asserted mid-operation clears everything immediately, including an in-flight tx_start.

## Test plan
- Reset then read every register of channels 0 and NCH-1 → CTRL 0, STATUS 0x00 (TXACT 0), IEN 0, BAUD 0x1A; channel NCH reads 0.
- Write CTRL ch1 = 0x05 with tx_active=0 → tx_start = 0b010 for one cycle; CTRL read = 0x04. Repeat with tx_active[1]=1 → no strobe.
- rx_done pulse on ch0, IEN0 = 0x80 → STATUS0 = 0x80, irq[0]=1 two cycles after the pulse. Second rx_done → STATUS0 = 0x90. Write STATUS0 = 0x80 → 0x10, irq[0]=0.
- tx_done on ch1 in the same cycle as a W1C write of 0x40 to STATUS1 → TXDONE remains 1.
- BAUD ch0 = 0x0C with simultaneous rd_en → rdata = 0x1A, next read = 0x0C; baud_o[7:0] = 0x0C.
- Assert init with STATUS/IEN populated and a GO write pending → all values return to reset, no tx_start. Async rst mid-stream → same result.
